key_expansion: RTL



---
 rtl/key_expansion_if.sv | 39 +++
 rtl/key_expansion.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/key_expansion_if.sv
// Block handshake plus key RAM, S-box ROM and round-key RAM ports of the AES-128 key schedule.
// The master modport is the key_expansion side; the slave modport is the memory/controller side.
interface key_expansion_if;
  logic        ap_start;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic [4:0]  key_address0;
  logic        key_ce0;
  logic [31:0] key_q0;
  logic [7:0]  sbox_address0;
  logic        sbox_ce0;
  logic [31:0] sbox_q0;
  logic [8:0]  word_address0;
  logic        word_ce0;
  logic        word_we0;
  logic [31:0] word_d0;
  logic [8:0]  word_address1;
  logic        word_ce1;
  logic [31:0] word_q1;

  modport master (
    input  ap_start, key_q0, sbox_q0, word_q1,
    output ap_done, ap_idle, ap_ready,
    output key_address0, key_ce0,
    output sbox_address0, sbox_ce0,
    output word_address0, word_ce0, word_we0, word_d0,
    output word_address1, word_ce1
  );

  modport slave (
    output ap_start, key_q0, sbox_q0, word_q1,
    input  ap_done, ap_idle, ap_ready,
    input  key_address0, key_ce0,
    input  sbox_address0, sbox_ce0,
    input  word_address0, word_ce0, word_we0, word_d0,
    input  word_address1, word_ce1
  );
endinterface

// File: rtl/key_expansion.sv
// AES-128 key schedule: copies the cipher key into word[] and expands it to 44 columns x 4 rows.
// Optional macro LOCK_KEY_EN adds working_key, which masks written bytes and gates completion.
module key_expansion #(
  parameter int NK         = 4,
  parameter int NCOL       = 44,
  parameter int ROW_STRIDE = 120
) (
  input  logic ap_clk,
  input  logic ap_rst,
`ifdef LOCK_KEY_EN
  input  logic [63:0] working_key,
`endif
  key_expansion_if.master bus
);

  typedef enum logic [2:0] {IDLE, CRD, CWR, XRP, XSB, XRO, XWR, DONE} state_t;

  state_t     state_reg, state_next;
  logic [5:0] i_reg, i_next;
  logic [1:0] j_reg, j_next;
  logic [7:0] temp_reg, temp_next;
  logic       pend_reg, pend_next;

  logic [7:0] lock_mask;
  logic       done_gate;
  logic       last_col;
  logic       last_copy;
  logic [8:0] wr_addr;

`ifdef LOCK_KEY_EN
  assign lock_mask = working_key[7:0] ^ 8'h96;
  assign done_gate = working_key[40];
  logic unused_lock;
  assign unused_lock = ^{working_key[63:41], working_key[39:8]};
`else
  assign lock_mask = 8'd0;
  assign done_gate = 1'b1;
`endif

  logic unused_bits;
  assign unused_bits = ^{bus.key_q0[31:8], bus.sbox_q0[31:8], bus.word_q1[31:8]};

  function automatic logic [8:0] row_base(input logic [1:0] r);
    return {7'd0, r} * 9'(ROW_STRIDE);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] v;
    case (idx)
      4'd0:    v = 8'h01;
      4'd1:    v = 8'h02;
      4'd2:    v = 8'h04;
      4'd3:    v = 8'h08;
      4'd4:    v = 8'h10;
      4'd5:    v = 8'h20;
      4'd6:    v = 8'h40;
      4'd7:    v = 8'h80;
      4'd8:    v = 8'h1b;
      4'd9:    v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  assign wr_addr   = row_base(j_reg) + {3'd0, i_reg};
  assign last_col  = (i_reg == 6'(NCOL - 1)) && (j_reg == 2'd3);
  assign last_copy = (i_reg == 6'(NK - 1)) && (j_reg == 2'd3);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_reg <= IDLE;
      i_reg     <= 6'd0;
      j_reg     <= 2'd0;
      temp_reg  <= 8'd0;
      pend_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      i_reg     <= i_next;
      j_reg     <= j_next;
      temp_reg  <= temp_next;
      pend_reg  <= pend_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    i_next            = i_reg;
    j_next            = j_reg;
    temp_next         = temp_reg;
    pend_next         = pend_reg;
    bus.ap_done       = 1'b0;
    bus.ap_idle       = 1'b0;
    bus.ap_ready      = 1'b0;
    bus.key_address0  = 5'd0;
    bus.key_ce0       = 1'b0;
    bus.sbox_address0 = 8'd0;
    bus.sbox_ce0      = 1'b0;
    bus.word_address0 = 9'd0;
    bus.word_ce0      = 1'b0;
    bus.word_we0      = 1'b0;
    bus.word_d0       = 32'd0;
    bus.word_address1 = 9'd0;
    bus.word_ce1      = 1'b0;

    case (state_reg)
      IDLE: begin
        bus.ap_idle = !bus.ap_start;
        if (bus.ap_start) begin
          i_next     = 6'd0;
          j_next     = 2'd0;
          state_next = CRD;
        end
      end

      CRD: begin
        bus.key_ce0      = 1'b1;
        bus.key_address0 = {i_reg[2:0], j_reg};
        state_next       = CWR;
      end

      CWR: begin
        bus.word_ce0      = 1'b1;
        bus.word_we0      = 1'b1;
        bus.word_address0 = wr_addr;
        bus.word_d0       = {24'd0, bus.key_q0[7:0] ^ lock_mask};
        j_next            = j_reg + 2'd1;
        if (j_reg == 2'd3) i_next = i_reg + 6'd1;
        // natural increment lands on i = NK, j = 0 for the first expanded column
        state_next = last_copy ? XRP : CRD;
      end

      XRP: begin
        bus.word_ce1 = 1'b1;
        if (i_reg[1:0] == 2'd0)
          bus.word_address1 = row_base(j_reg + 2'd1) + {3'd0, i_reg} - 9'd1;
        else
          bus.word_address1 = row_base(j_reg) + {3'd0, i_reg} - 9'd1;
        state_next = XSB;
      end

      XSB: begin
        if (i_reg[1:0] == 2'd0) begin
          bus.sbox_ce0      = 1'b1;
          bus.sbox_address0 = bus.word_q1[7:0];
          pend_next         = 1'b1;
        end else begin
          temp_next = bus.word_q1[7:0];
          pend_next = 1'b0;
        end
        state_next = XRO;
      end

      XRO: begin
        if (pend_reg) begin
          if (j_reg == 2'd0)
            temp_next = bus.sbox_q0[7:0] ^ rcon(i_reg[5:2] - 4'd1);
          else
            temp_next = bus.sbox_q0[7:0];
        end
        bus.word_ce1      = 1'b1;
        bus.word_address1 = wr_addr - 9'd4;
        state_next        = XWR;
      end

      XWR: begin
        bus.word_ce0      = 1'b1;
        bus.word_we0      = 1'b1;
        bus.word_address0 = wr_addr;
        bus.word_d0       = {24'd0, bus.word_q1[7:0] ^ temp_reg ^ lock_mask};
        j_next            = j_reg + 2'd1;
        if (j_reg == 2'd3) i_next = i_reg + 6'd1;
        if (last_col) begin
          if (done_gate) begin
            state_next = DONE;
          end else begin
            // locked: restart expansion without ever completing
            i_next     = 6'(NK);
            j_next     = 2'd0;
            state_next = XRP;
          end
        end else begin
          state_next = XRP;
        end
      end

      DONE: begin
        bus.ap_done  = 1'b1;
        bus.ap_ready = 1'b1;
        state_next   = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule
